alive_census: RTL and testbench

- Sequential population counter between the Game-of-Life state machine and the seven-segment driver.
- On a start pulse, one per generation, it snapshots the grid state vector.
- It then popcounts the snapshot one row per cycle and converts the total to 4-digit BCD with a serial double-dabble.
- Results are presented atomically with a one-cycle done pulse, replacing the single-cycle combinational count with a bounded-latency, low-area pipeline.

---
 rtl/conway_pkg.sv | 21 ++
 rtl/alive_census_bin2bcd.sv | 54 +++++
 rtl/alive_census.sv | 138 +++++++++++++
 tb/tb_alive_census.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared Game-of-Life constants, census FSM state type and grid index helper.
package conway_pkg;

    localparam int MAX_X      = 40;
    localparam int MAX_Y      = 30;
    localparam int S_SIZE     = MAX_X * MAX_Y;
    localparam int CNT_W      = 12;
    localparam int BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_SCAN,
        CS_CONV,
        CS_DONE
    } census_state_t;

    function automatic int unsigned idx(input int unsigned y, input int unsigned x);
        return y * MAX_X + x;
    endfunction

endpackage

// File: rtl/alive_census_bin2bcd.sv
// Serial double-dabble: converts BIN_W bits to DIGITS BCD nibbles, one bit per clock, MSB first.
module bin2bcd_seq #(
    parameter int BIN_W  = conway_pkg::CNT_W,
    parameter int DIGITS = conway_pkg::BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    shreg;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;

    always_comb begin
        adj = acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    // done marks the cycle whose closing edge performs the final shift
    assign done = busy && (cnt == CW'(1));
    assign bcd  = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            shreg <= bin;
            acc   <= '0;
            cnt   <= CW'(BIN_W);
            busy  <= 1'b1;
        end else if (busy) begin
            acc   <= {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
            shreg <= shreg << 1;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alive_census.sv
// Sequential live-cell census: snapshot grid, popcount one row per clock, serial BCD convert.
// Optional `CENSUS_STABLE_EN adds a 'stable' output flagging an unchanged count between censuses.
module alive_census #(
    parameter int MAX_X = conway_pkg::MAX_X,
    parameter int MAX_Y = conway_pkg::MAX_Y,
    parameter int CNT_W = conway_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MAX_X*MAX_Y-1:0] state,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       alive_count,
    output logic [15:0]            alive_bcd
`ifdef CENSUS_STABLE_EN
    ,
    output logic                   stable
`endif
);

    localparam int S_SIZE = MAX_X * MAX_Y;
    localparam int ROW_W  = $clog2(MAX_Y);
    localparam int PC_W   = $clog2(MAX_X + 1);

    conway_pkg::census_state_t fsm, fsm_next;

    logic [S_SIZE-1:0] snapshot;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_next;
    logic [ROW_W-1:0]  row;
    logic              last_row;
    logic [PC_W-1:0]   row_count;
    logic              conv_load;
    logic              conv_busy;
    logic              conv_done;
    logic [15:0]       conv_bcd;

    function automatic logic [PC_W-1:0] row_pop(input logic [MAX_X-1:0] r);
        logic [PC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_X; i++)
            n = n + PC_W'(r[i]);
        return n;
    endfunction

    assign row_count = row_pop(snapshot[row*MAX_X +: MAX_X]);
    assign acc_next  = acc + CNT_W'(row_count);
    assign last_row  = (row == ROW_W'(MAX_Y - 1));

    always_ff @(posedge clk) begin
        if (rst)
            fsm <= conway_pkg::CS_IDLE;
        else
            fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            conway_pkg::CS_IDLE: if (start)    fsm_next = conway_pkg::CS_SCAN;
            conway_pkg::CS_SCAN: if (last_row) fsm_next = conway_pkg::CS_CONV;
            // falling out on an idle converter guards against a lost load
            conway_pkg::CS_CONV: if (conv_done || !conv_busy) fsm_next = conway_pkg::CS_DONE;
            conway_pkg::CS_DONE: fsm_next = conway_pkg::CS_IDLE;
            default:             fsm_next = conway_pkg::CS_IDLE;
        endcase
    end

    always_comb begin
        busy      = (fsm != conway_pkg::CS_IDLE);
        conv_load = (fsm == conway_pkg::CS_SCAN) && last_row;
    end

    // converter is loaded with the final sum on the last scan edge
    bin2bcd_seq #(
        .BIN_W  (CNT_W),
        .DIGITS (conway_pkg::BCD_DIGITS)
    ) u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (conv_load),
        .bin  (acc_next),
        .busy (conv_busy),
        .done (conv_done),
        .bcd  (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot    <= '0;
            acc         <= '0;
            row         <= '0;
            done        <= 1'b0;
            alive_count <= '0;
            alive_bcd   <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                conway_pkg::CS_IDLE: begin
                    if (start) begin
                        snapshot <= state;
                        acc      <= '0;
                        row      <= '0;
                    end
                end
                conway_pkg::CS_SCAN: begin
                    acc <= acc_next;
                    row <= row + ROW_W'(1);
                end
                conway_pkg::CS_DONE: begin
                    alive_count <= acc;
                    alive_bcd   <= conv_bcd;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CENSUS_STABLE_EN
    logic [CNT_W-1:0] prev_count;
    logic             valid_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable     <= 1'b0;
            prev_count <= '0;
            valid_prev <= 1'b0;
        end else if (fsm == conway_pkg::CS_DONE) begin
            stable     <= valid_prev && (acc == prev_count);
            prev_count <= acc;
            valid_prev <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alive_census.sv
// Directed self-checking bench for alive_census (covers `CENSUS_STABLE_EN when defined).
module tb_alive_census;
    import conway_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [S_SIZE-1:0] state;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  alive_count;
    logic [15:0]       alive_bcd;
`ifdef CENSUS_STABLE_EN
    logic              stable;
`endif

    int compared   = 0;
    int mismatched = 0;
    int lat;
    int extra;
    logic [S_SIZE-1:0] pat;

    alive_census #(
        .MAX_X (MAX_X),
        .MAX_Y (MAX_Y),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state       (state),
        .busy        (busy),
        .done        (done),
        .alive_count (alive_count),
        .alive_bcd   (alive_bcd)
`ifdef CENSUS_STABLE_EN
        ,
        .stable      (stable)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [S_SIZE-1:0] first_n(input int n);
        logic [S_SIZE-1:0] p;
        p = '0;
        for (int i = 0; i < n; i++)
            p[i] = 1'b1;
        return p;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic accept(input logic [S_SIZE-1:0] p);
        state = p;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // counts edges after the accepting edge until done; optionally re-pulses start mid-census
    task automatic wait_done(input string tag, input bit poke, output int l);
        l = -1;
        for (int k = 1; k <= 100; k++) begin
            start = poke && (k == 5 || k == 20);
            @(posedge clk);
            #1 start = 1'b0;
            if (done === 1'b1) begin
                l = k;
                break;
            end
            if (k == 1 || k == 42)
                check({tag, " busy"}, 32'(busy), 32'd1);
        end
    endtask

    task automatic census(input string tag, input logic [S_SIZE-1:0] p,
                          input int exp_cnt, input logic [15:0] exp_bcd);
        int l;
        accept(p);
        wait_done(tag, 1'b0, l);
        check({tag, " latency"}, 32'(l), 32'd43);
        check({tag, " count"}, 32'(alive_count), 32'(exp_cnt));
        check({tag, " bcd"}, 32'(alive_bcd), 32'(exp_bcd));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        state = '0;
        do_reset();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset count", 32'(alive_count), 32'd0);
        check("reset bcd", 32'(alive_bcd), 32'h0000);

        census("empty", '0, 0, 16'h0000);
        census("full", '1, 1200, 16'h1200);

        pat = '0;
        pat[idx(0, 0)]   = 1'b1;
        pat[idx(0, 39)]  = 1'b1;
        pat[idx(29, 0)]  = 1'b1;
        pat[idx(29, 39)] = 1'b1;
        pat[idx(1, 2)]   = 1'b1;
        pat[idx(2, 3)]   = 1'b1;
        pat[idx(3, 1)]   = 1'b1;
        pat[idx(3, 2)]   = 1'b1;
        pat[idx(3, 3)]   = 1'b1;
        census("corners", pat, 9, 16'h0009);

        census("n999", first_n(999), 999, 16'h0999);

        // snapshot isolation and start-while-busy
        accept(first_n(5));
        state = '1;
        wait_done("snap", 1'b1, lat);
        check("snap latency", 32'(lat), 32'd43);
        check("snap count", 32'(alive_count), 32'd5);
        check("snap bcd", 32'(alive_bcd), 32'h0005);
        extra = 0;
        repeat (45) begin
            @(posedge clk);
            #1 if (done === 1'b1) extra++;
        end
        check("snap single done", 32'(extra), 32'd0);
        census("after snap", '1, 1200, 16'h1200);

        // reset during scan aborts the census
        accept('1);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort count", 32'(alive_count), 32'd0);
        check("abort bcd", 32'(alive_bcd), 32'h0000);
        extra = 0;
        repeat (50) begin
            @(posedge clk);
            #1 if (done === 1'b1) extra++;
        end
        check("abort no done", 32'(extra), 32'd0);
        census("seven", first_n(7), 7, 16'h0007);

`ifdef CENSUS_STABLE_EN
        do_reset();
        check("stable reset", 32'(stable), 32'd0);
        census("st12a", first_n(12), 12, 16'h0012);
        check("stable first", 32'(stable), 32'd0);
        census("st12b", first_n(12), 12, 16'h0012);
        check("stable repeat", 32'(stable), 32'd1);
        census("st13", first_n(13), 13, 16'h0013);
        check("stable change", 32'(stable), 32'd0);
        do_reset();
        census("st12c", first_n(12), 12, 16'h0012);
        check("stable after reset", 32'(stable), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
